npu_queue_port: RTL and testbench

//  - Parametrised NPU queue interface for the execute stage; replaces the bare config/data/dequeue strobes.
//  - Buffers config words and data words toward the NPU, and result words back from it, each with a ready/valid handshake.
//  - Raises a stall request on full or empty; a dequeue timeout FSM stops the pipeline from hanging on a dead NPU.

---
 rtl/npu_queue_port_pkg.sv | 15 +
 rtl/npu_sync_fifo.sv | 64 ++++++
 rtl/npu_queue_port.sv | 152 +++++++++++++++
 tb/tb_npu_queue_port.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_queue_port_pkg.sv
// Shared types for the NPU queue port: timeout FSM state encoding and width helper.
package npu_queue_port_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } npu_state_e;

    // Occupancy counters need one extra bit so that a full queue is representable.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and registered occupancy level.
module npu_sync_fifo
    import npu_queue_port_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = lvl_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage is deliberately left out of reset; only pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/npu_queue_port.sv
// Execute-stage NPU queue port: config/data queues toward the NPU, result queue back,
// pipeline stall request and a dequeue timeout FSM.
module npu_queue_port
    import npu_queue_port_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CFG_DEPTH   = 8,
    parameter int unsigned DATA_DEPTH  = 16,
    parameter int unsigned RES_DEPTH   = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                           iClk,
    input  logic                           iRst,
    input  logic                           iStall,
    input  logic                           iCfgOp,
    input  logic [DATA_W-1:0]              iCfgWord,
    input  logic                           iEnqOp,
    input  logic [DATA_W-1:0]              iEnqData,
    input  logic                           iDeqOp,
    output logic [DATA_W-1:0]              oDeqData,
    output logic                           oStallReq,
    output logic                           oTimeout,
    input  logic                           iClrTimeout,
    output logic                           oNpuCfgValid,
    output logic [DATA_W-1:0]              oNpuCfgData,
    input  logic                           iNpuCfgReady,
    output logic                           oNpuDataValid,
    output logic [DATA_W-1:0]              oNpuData,
    input  logic                           iNpuDataReady,
    input  logic                           iNpuResValid,
    input  logic [DATA_W-1:0]              iNpuResData,
    output logic                           oNpuResReady,
    output logic [$clog2(CFG_DEPTH):0]     oCfgLevel,
    output logic [$clog2(DATA_DEPTH):0]    oDataLevel,
    output logic [$clog2(RES_DEPTH):0]     oResLevel
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    npu_state_e       state;
    npu_state_e       next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;

    logic cfg_full, cfg_empty, cfg_push, cfg_pop;
    logic data_full, data_empty, data_push, data_pop;
    logic res_full, res_empty, res_push, res_pop;
    logic [DATA_W-1:0] res_head;
    logic deq_live;
    logic res_blocked;

    assign deq_live    = (state != S_FAULT);
    assign res_blocked = iDeqOp & res_empty;

    assign cfg_push  = iCfgOp & ~iStall & ~cfg_full;
    assign cfg_pop   = oNpuCfgValid & iNpuCfgReady;
    assign data_push = iEnqOp & ~iStall & ~data_full;
    assign data_pop  = oNpuDataValid & iNpuDataReady;
    assign res_push  = iNpuResValid & oNpuResReady;
    assign res_pop   = iDeqOp & ~iStall & ~res_empty & deq_live;

    assign oNpuCfgValid  = ~cfg_empty;
    assign oNpuDataValid = ~data_empty;
    assign oNpuResReady  = ~res_full;

    // In fault the dequeue path is dead: it returns zero and never stalls.
    assign oDeqData  = (deq_live & ~res_empty) ? res_head : '0;
    assign oStallReq = (iCfgOp & cfg_full) | (iEnqOp & data_full) | (res_blocked & deq_live);
    assign oTimeout  = (state == S_FAULT);

    npu_sync_fifo #(.WIDTH(DATA_W), .DEPTH(CFG_DEPTH)) u_cfg_fifo (
        .clk   (iClk),
        .rst   (iRst),
        .push  (cfg_push),
        .pop   (cfg_pop),
        .din   (iCfgWord),
        .head  (oNpuCfgData),
        .full  (cfg_full),
        .empty (cfg_empty),
        .level (oCfgLevel)
    );

    npu_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk   (iClk),
        .rst   (iRst),
        .push  (data_push),
        .pop   (data_pop),
        .din   (iEnqData),
        .head  (oNpuData),
        .full  (data_full),
        .empty (data_empty),
        .level (oDataLevel)
    );

    npu_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk   (iClk),
        .rst   (iRst),
        .push  (res_push),
        .pop   (res_pop),
        .din   (iNpuResData),
        .head  (res_head),
        .full  (res_full),
        .empty (res_empty),
        .level (oResLevel)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        unique case (state)
            S_RUN: begin
                if (res_blocked & ~iStall) begin
                    next_state = S_WAIT;
                    next_cnt   = CNT_ONE;
                end
            end
            S_WAIT: begin
                if (!res_blocked) begin
                    next_state = S_RUN;
                    next_cnt   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = S_FAULT;
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end
            S_FAULT: begin
                if (iClrTimeout) begin
                    next_state = S_RUN;
                    next_cnt   = '0;
                end
            end
            default: begin
                next_state = S_RUN;
                next_cnt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_npu_queue_port.sv
// Directed bench for npu_queue_port with small timeout; expected values are hand-computed.
module tb_npu_queue_port;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStall, iCfgOp, iEnqOp, iDeqOp, iClrTimeout;
    logic [31:0] iCfgWord, iEnqData, iNpuResData;
    logic        iNpuCfgReady, iNpuDataReady, iNpuResValid;
    logic [31:0] oDeqData, oNpuCfgData, oNpuData;
    logic        oStallReq, oTimeout, oNpuCfgValid, oNpuDataValid, oNpuResReady;
    logic [3:0]  oCfgLevel;
    logic [4:0]  oDataLevel, oResLevel;

    int checks = 0;
    int errors = 0;

    always #5 iClk = ~iClk;

    npu_queue_port #(
        .DATA_W(32), .CFG_DEPTH(8), .DATA_DEPTH(16), .RES_DEPTH(16), .TIMEOUT_CYC(4)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iStall(iStall),
        .iCfgOp(iCfgOp), .iCfgWord(iCfgWord),
        .iEnqOp(iEnqOp), .iEnqData(iEnqData),
        .iDeqOp(iDeqOp), .oDeqData(oDeqData),
        .oStallReq(oStallReq), .oTimeout(oTimeout), .iClrTimeout(iClrTimeout),
        .oNpuCfgValid(oNpuCfgValid), .oNpuCfgData(oNpuCfgData), .iNpuCfgReady(iNpuCfgReady),
        .oNpuDataValid(oNpuDataValid), .oNpuData(oNpuData), .iNpuDataReady(iNpuDataReady),
        .iNpuResValid(iNpuResValid), .iNpuResData(iNpuResData), .oNpuResReady(oNpuResReady),
        .oCfgLevel(oCfgLevel), .oDataLevel(oDataLevel), .oResLevel(oResLevel)
    );

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic clear_inputs();
        iStall = 0; iCfgOp = 0; iEnqOp = 0; iDeqOp = 0; iClrTimeout = 0;
        iCfgWord = '0; iEnqData = '0; iNpuResData = '0;
        iNpuCfgReady = 0; iNpuDataReady = 0; iNpuResValid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        iRst = 1;
        step();
        step();
        iRst = 0;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        iRst = 1;
        #3;
        step();
        checks++; if (oCfgLevel !== 4'd0 || oDataLevel !== 5'd0 || oResLevel !== 5'd0) begin
            errors++; $display("FAIL reset_levels got %0d/%0d/%0d exp 0/0/0", oCfgLevel, oDataLevel, oResLevel); end
        checks++; if (oNpuCfgValid !== 1'b0 || oNpuDataValid !== 1'b0) begin
            errors++; $display("FAIL reset_valids got %b%b exp 00", oNpuCfgValid, oNpuDataValid); end
        checks++; if (oNpuResReady !== 1'b1 || oStallReq !== 1'b0 || oTimeout !== 1'b0) begin
            errors++; $display("FAIL reset_flags got rdy=%b stall=%b to=%b exp 1 0 0", oNpuResReady, oStallReq, oTimeout); end
        checks++; if (oDeqData !== 32'h0) begin
            errors++; $display("FAIL reset_deq got %h exp 00000000", oDeqData); end
        iRst = 0;
        step();
    endtask

    task automatic test_cfg_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            iCfgOp = 1; iCfgWord = 32'd100 + i;
            #1;
            checks++; if (oStallReq !== 1'b0) begin
                errors++; $display("FAIL cfg_fill_stall%0d got %b exp 0", i, oStallReq); end
            step();
        end
        checks++; if (oCfgLevel !== 4'd8 || oNpuCfgData !== 32'd100) begin
            errors++; $display("FAIL cfg_full_level got %0d head %0d exp 8 100", oCfgLevel, oNpuCfgData); end
        iCfgWord = 32'd108;
        #1;
        checks++; if (oStallReq !== 1'b1) begin
            errors++; $display("FAIL cfg_ninth_stall got %b exp 1", oStallReq); end
        step();
        checks++; if (oCfgLevel !== 4'd8) begin
            errors++; $display("FAIL cfg_ninth_reject got %0d exp 8", oCfgLevel); end
        iNpuCfgReady = 1;
        #1;
        checks++; if (oStallReq !== 1'b1) begin
            errors++; $display("FAIL cfg_pop_full_stall got %b exp 1", oStallReq); end
        step();
        checks++; if (oCfgLevel !== 4'd7 || oNpuCfgData !== 32'd101) begin
            errors++; $display("FAIL cfg_after_pop got %0d head %0d exp 7 101", oCfgLevel, oNpuCfgData); end
        iNpuCfgReady = 0;
        #1;
        checks++; if (oStallReq !== 1'b0) begin
            errors++; $display("FAIL cfg_retry_stall got %b exp 0", oStallReq); end
        step();
        checks++; if (oCfgLevel !== 4'd8) begin
            errors++; $display("FAIL cfg_retry_level got %0d exp 8", oCfgLevel); end
        iCfgOp = 0; iNpuCfgReady = 1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (oNpuCfgValid !== 1'b1 || oNpuCfgData !== 32'd100 + i) begin
                errors++; $display("FAIL cfg_drain%0d got v=%b %0d exp 1 %0d", i, oNpuCfgValid, oNpuCfgData, 100 + i); end
            step();
        end
        iNpuCfgReady = 0;
        checks++; if (oCfgLevel !== 4'd0 || oNpuCfgValid !== 1'b0) begin
            errors++; $display("FAIL cfg_empty got %0d v=%b exp 0 0", oCfgLevel, oNpuCfgValid); end
    endtask

    task automatic test_data_full_pop();
        do_reset();
        iEnqOp = 1;
        for (int i = 0; i < 16; i++) begin
            iEnqData = 32'd200 + i;
            step();
        end
        iEnqData = 32'd216;
        checks++; if (oDataLevel !== 5'd16) begin
            errors++; $display("FAIL data_full_level got %0d exp 16", oDataLevel); end
        iNpuDataReady = 1;
        #1;
        checks++; if (oStallReq !== 1'b1) begin
            errors++; $display("FAIL data_full_pop_stall got %b exp 1", oStallReq); end
        step();
        checks++; if (oDataLevel !== 5'd15 || oNpuData !== 32'd201) begin
            errors++; $display("FAIL data_full_pop_level got %0d head %0d exp 15 201", oDataLevel, oNpuData); end
        iNpuDataReady = 0;
        step();
        checks++; if (oDataLevel !== 5'd16) begin
            errors++; $display("FAIL data_retry_level got %0d exp 16", oDataLevel); end
        iEnqOp = 0; iNpuDataReady = 1;
        for (int i = 1; i <= 16; i++) begin
            checks++; if (oNpuData !== 32'd200 + i) begin
                errors++; $display("FAIL data_drain%0d got %0d exp %0d", i, oNpuData, 200 + i); end
            step();
        end
        iNpuDataReady = 0;
        checks++; if (oDataLevel !== 5'd0 || oNpuDataValid !== 1'b0) begin
            errors++; $display("FAIL data_empty got %0d v=%b exp 0 0", oDataLevel, oNpuDataValid); end
    endtask

    task automatic test_dual_push();
        do_reset();
        iCfgOp = 1; iCfgWord = 32'hC0FFEE01; iEnqOp = 1; iEnqData = 32'hDA7A0001;
        step();
        clear_inputs();
        checks++; if (oCfgLevel !== 4'd1 || oDataLevel !== 5'd1) begin
            errors++; $display("FAIL dual_levels got %0d/%0d exp 1/1", oCfgLevel, oDataLevel); end
        checks++; if (oNpuCfgData !== 32'hC0FFEE01 || oNpuData !== 32'hDA7A0001) begin
            errors++; $display("FAIL dual_heads got %h/%h exp c0ffee01/da7a0001", oNpuCfgData, oNpuData); end
    endtask

    task automatic test_result_latency();
        do_reset();
        iNpuResValid = 1; iNpuResData = 32'hDEADBEEF; iDeqOp = 1;
        #1;
        checks++; if (oStallReq !== 1'b1 || oDeqData !== 32'h0) begin
            errors++; $display("FAIL res_same_cycle got stall=%b %h exp 1 00000000", oStallReq, oDeqData); end
        step();
        iNpuResValid = 0;
        #1;
        checks++; if (oStallReq !== 1'b0 || oDeqData !== 32'hDEADBEEF || oResLevel !== 5'd1) begin
            errors++; $display("FAIL res_next_cycle got stall=%b %h lvl %0d exp 0 deadbeef 1", oStallReq, oDeqData, oResLevel); end
        step();
        iDeqOp = 0;
        checks++; if (oResLevel !== 5'd0 || oDeqData !== 32'h0) begin
            errors++; $display("FAIL res_popped got lvl %0d %h exp 0 00000000", oResLevel, oDeqData); end
    endtask

    task automatic test_timeout();
        do_reset();
        iDeqOp = 1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (oStallReq !== 1'b1 || oTimeout !== 1'b0) begin
                errors++; $display("FAIL to_blocked%0d got stall=%b to=%b exp 1 0", k, oStallReq, oTimeout); end
            step();
        end
        checks++; if (oTimeout !== 1'b1 || oStallReq !== 1'b0 || oDeqData !== 32'h0) begin
            errors++; $display("FAIL to_fault got to=%b stall=%b %h exp 1 0 00000000", oTimeout, oStallReq, oDeqData); end
        iCfgOp = 1; iCfgWord = 32'h11;
        step();
        iCfgOp = 0;
        checks++; if (oCfgLevel !== 4'd1) begin
            errors++; $display("FAIL to_cfg_push got %0d exp 1", oCfgLevel); end
        iNpuResValid = 1; iNpuResData = 32'h55;
        step();
        iNpuResValid = 0;
        #1;
        checks++; if (oDeqData !== 32'h0 || oStallReq !== 1'b0 || oResLevel !== 5'd1) begin
            errors++; $display("FAIL to_fault_deq got %h stall=%b lvl %0d exp 0 0 1", oDeqData, oStallReq, oResLevel); end
        step();
        checks++; if (oResLevel !== 5'd1 || oTimeout !== 1'b1) begin
            errors++; $display("FAIL to_fault_nopop got lvl %0d to=%b exp 1 1", oResLevel, oTimeout); end
        iDeqOp = 0; iClrTimeout = 1;
        step();
        iClrTimeout = 0;
        checks++; if (oTimeout !== 1'b0) begin
            errors++; $display("FAIL to_clear got %b exp 0", oTimeout); end
        iDeqOp = 1;
        #1;
        checks++; if (oDeqData !== 32'h55 || oStallReq !== 1'b0) begin
            errors++; $display("FAIL to_run_deq got %h stall=%b exp 00000055 0", oDeqData, oStallReq); end
        step();
        iDeqOp = 0;
        checks++; if (oResLevel !== 5'd0) begin
            errors++; $display("FAIL to_run_pop got %0d exp 0", oResLevel); end
    endtask

    task automatic test_stall_gating();
        do_reset();
        iStall = 1; iCfgOp = 1; iEnqOp = 1; iDeqOp = 1; iCfgWord = 32'h1; iEnqData = 32'h2;
        #1;
        checks++; if (oStallReq !== 1'b1) begin
            errors++; $display("FAIL stall_empty_req got %b exp 1", oStallReq); end
        step();
        checks++; if (oCfgLevel !== 4'd0 || oDataLevel !== 5'd0 || oResLevel !== 5'd0) begin
            errors++; $display("FAIL stall_hold1 got %0d/%0d/%0d exp 0/0/0", oCfgLevel, oDataLevel, oResLevel); end
        clear_inputs();
        iNpuResValid = 1; iNpuResData = 32'h77;
        step();
        iNpuResValid = 0;
        iStall = 1; iCfgOp = 1; iEnqOp = 1; iDeqOp = 1;
        #1;
        checks++; if (oStallReq !== 1'b0) begin
            errors++; $display("FAIL stall_nonempty_req got %b exp 0", oStallReq); end
        step();
        checks++; if (oCfgLevel !== 4'd0 || oDataLevel !== 5'd0 || oResLevel !== 5'd1) begin
            errors++; $display("FAIL stall_hold2 got %0d/%0d/%0d exp 0/0/1", oCfgLevel, oDataLevel, oResLevel); end
        clear_inputs();
    endtask

    task automatic test_mid_reset();
        do_reset();
        iCfgOp = 1;
        for (int i = 0; i < 3; i++) begin
            iCfgWord = 32'd300 + i;
            step();
        end
        iCfgOp = 0;
        checks++; if (oCfgLevel !== 4'd3) begin
            errors++; $display("FAIL mid_prefill got %0d exp 3", oCfgLevel); end
        #2;
        iRst = 1;
        #1;
        checks++; if (oCfgLevel !== 4'd0 || oNpuCfgValid !== 1'b0 || oNpuDataValid !== 1'b0 || oTimeout !== 1'b0) begin
            errors++; $display("FAIL mid_reset got lvl %0d v=%b%b to=%b exp 0 00 0", oCfgLevel, oNpuCfgValid, oNpuDataValid, oTimeout); end
        step();
        iRst = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_cfg_fill();
        test_data_full_pop();
        test_dual_push();
        test_result_latency();
        test_timeout();
        test_stall_gating();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
